fsm_ctrl_param: RTL

Parametrised multi-cycle control unit for the accumulator-style datapath: fetch, decode, operand fetch, execute/write-back and PC update. It extends the basic four-op controller with a wider opcode field, logic ops, conditional jump, halt, illegal-opcode detection and an optional memory-ready wait handshake. It sits between the instruction register (`operacion`) and the datapath enables, muxes and ALU select.

---
 rtl/fsm_ctrl_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fsm_ctrl_param.sv
// Multi-cycle control unit for the accumulator datapath: fetch, decode, operand
// fetch, execute/write-back and PC update, with an optional memory-ready wait.
module fsm_ctrl_param #(
  parameter int unsigned OPW      = 3,
  parameter int unsigned SELW     = 3,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  operacion,
  input  logic            flag_cero,
  input  logic            mem_listo,
  output logic            enmem,
  output logic            wrmem,
  output logic            enir,
  output logic            enrop1,
  output logic            enrop2,
  output logic            enrio,
  output logic            enpc,
  output logic            ldpc,
  output logic [SELW-1:0] seloper,
  output logic [1:0]      selmux,
  output logic            halt,
  output logic            err,
  output logic [3:0]      estado
);

  localparam logic [3:0] S_F    = 4'd0;
  localparam logic [3:0] S_D    = 4'd1;
  localparam logic [3:0] S_OP1  = 4'd2;
  localparam logic [3:0] S_OP2  = 4'd3;
  localparam logic [3:0] S_WC   = 4'd4;
  localparam logic [3:0] S_COU  = 4'd5;
  localparam logic [3:0] S_GA   = 4'd6;
  localparam logic [3:0] S_WB   = 4'd7;
  localparam logic [3:0] S_OA   = 4'd8;
  localparam logic [3:0] S_JP   = 4'd9;
  localparam logic [3:0] S_HALT = 4'd10;

  logic [3:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           err_q, err_d;
  logic           illegal;
  logic           mem_state;
  logic           stall;

  // Widened compare so the check stays correct for any OPW >= 3.
  assign illegal = (32'(operacion) >= 32'd8);

  always_comb begin
    mem_state = 1'b0;
    case (state_q)
      S_F, S_OP1, S_OP2, S_WC, S_GA, S_WB: mem_state = 1'b1;
      default:                             mem_state = 1'b0;
    endcase
  end

  assign stall = (MEM_WAIT != 0) && mem_state && !mem_listo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_F;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state, opcode capture and sticky illegal flag.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      S_F:   state_d = S_D;
      S_D: begin
        op_d = operacion;
        if (illegal) begin
          state_d = S_COU;
          err_d   = 1'b1;
        end else begin
          case (operacion[2:0])
            3'd0, 3'd1, 3'd4, 3'd5: state_d = S_OP1;
            3'd2:                   state_d = S_GA;
            3'd3:                   state_d = S_OA;
            3'd6:                   state_d = S_JP;
            default:                state_d = S_HALT;
          endcase
        end
      end
      S_OP1:  state_d = S_OP2;
      S_OP2:  state_d = S_WC;
      S_WC:   state_d = S_COU;
      S_GA:   state_d = S_WB;
      S_WB:   state_d = S_COU;
      S_OA:   state_d = S_COU;
      S_JP:   state_d = flag_cero ? S_F : S_COU;
      S_COU:  state_d = S_F;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F;
    endcase
    if (stall) state_d = state_q;
  end

  // Moore decode of the registered state; ldpc alone follows flag_cero live.
  always_comb begin
    enmem   = 1'b0;
    wrmem   = 1'b0;
    enir    = 1'b0;
    enrop1  = 1'b0;
    enrop2  = 1'b0;
    enrio   = 1'b0;
    enpc    = 1'b0;
    ldpc    = 1'b0;
    halt    = 1'b0;
    selmux  = 2'b00;
    seloper = '0;
    case (state_q)
      S_F: begin
        enmem = 1'b1;
        enir  = 1'b1;
      end
      S_OP1, S_GA: begin
        enmem  = 1'b1;
        enrop1 = 1'b1;
        selmux = 2'b01;
      end
      S_OP2: begin
        enmem   = 1'b1;
        enrop2  = 1'b1;
        selmux  = 2'b10;
        seloper = SELW'(op_q[2:0]);
      end
      S_WC: begin
        enmem   = 1'b1;
        wrmem   = 1'b1;
        selmux  = 2'b11;
        seloper = SELW'(op_q[2:0]);
      end
      S_WB: begin
        enmem   = 1'b1;
        wrmem   = 1'b1;
        selmux  = 2'b10;
        seloper = SELW'(op_q[2:0]);
      end
      S_OA: begin
        enrio  = 1'b1;
        selmux = 2'b01;
      end
      S_COU:  enpc = 1'b1;
      S_JP:   ldpc = flag_cero;
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign err    = err_q;
  assign estado = state_q;

endmodule
